// File: rtl/mux_n_1_stream_if.sv
// Stream bundle between N producer channels, the N:1 mux and one consumer.
// slave  : the mux side (takes producer beats, drives the consumer side).
// master : the environment side (producers plus consumer).
interface mux_n_1_stream_if #(
   parameter int WIDTH = 8,
   parameter int N     = 4
);
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_last;
   logic [N-1:0]       in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic               out_last;
   logic               out_ready;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last
   );
endinterface

// File: rtl/mux_n_1_stream.sv
// N:1 handshaked stream multiplexer with packet locking and a registered
// output stage. Channel choice comes from an external select (mode=0) or a
// round-robin arbiter (mode=1); a multi-beat packet keeps its channel until
// the beat carrying last has been accepted.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no packet open; mode/sel choose the candidate each cycle
//   LOCKED | multi-beat packet open on grant_idx; only that channel moves
module mux_n_1_stream #(
   parameter int WIDTH = 8,
   parameter int N     = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mux_n_1_stream_if.slave      bus,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [SELW-1:0]      grant_idx,
   output logic                 busy
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [SELW-1:0]   rr_ptr;
   logic [SELW-1:0]   cand;
   logic              cand_ok;
   logic [SELW-1:0]   act;
   logic              act_ok;
   logic              can_load;
   logic              xfer;
   logic              act_valid;
   logic              act_last;
   logic [WIDTH-1:0]  act_data;
   logic [WIDTH-1:0]  out_data_q;
   logic              out_valid_q;
   logic              out_last_q;
   int                idx;

   assign can_load = !out_valid_q || bus.out_ready;

   // Candidate channel while IDLE: external select, or first valid channel
   // after the round-robin pointer.
   always_comb begin
      cand_ok = 1'b0;
      cand    = '0;
      idx     = 0;
      if (!mode) begin
         if (int'(sel) < N) begin
            cand_ok = 1'b1;
            cand    = sel;
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!cand_ok && bus.in_valid[idx]) begin
               cand_ok = 1'b1;
               cand    = SELW'(idx);
            end
         end
      end
   end

   // Active channel: the locked one, otherwise the IDLE candidate.
   always_comb begin
      act    = cand;
      act_ok = cand_ok;
      if (state == LOCKED) begin
         act    = grant_idx;
         act_ok = 1'b1;
      end
   end

   // Per-channel ready and the mux of the active channel's beat. Ready is
   // held low during reset so no producer sees a phantom accept.
   always_comb begin
      bus.in_ready = '0;
      act_valid    = 1'b0;
      act_last     = 1'b0;
      act_data     = '0;
      for (int i = 0; i < N; i++) begin
         if (act_ok && (int'(act) == i)) begin
            bus.in_ready[i] = can_load && rst_n;
            act_valid       = bus.in_valid[i];
            act_last        = bus.in_last[i];
            act_data        = bus.in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer = act_ok && can_load && rst_n && act_valid;

   // Next-state: open a lock on a non-last beat, release it on the last beat.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (xfer && !act_last) state_nxt = LOCKED;
         LOCKED:  if (xfer &&  act_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, grant/pointer bookkeeping and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         grant_idx <= '0;
         rr_ptr    <= SELW'(N - 1);
         busy      <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == LOCKED);
         if (xfer && (state == IDLE)) grant_idx <= act;
         if (xfer && act_last)        rr_ptr    <= act;
      end
   end

   // Output register: loads whenever the slot is empty or being drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else if (can_load) begin
         out_valid_q <= xfer;
         if (xfer) begin
            out_data_q <= act_data;
            out_last_q <= act_last;
         end
      end
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_last  = out_last_q;

endmodule
